// File: rtl/nnoc_pkg.sv
// rtl/nnoc_pkg.sv - shared nnoc constants and the RX word FIFO entry layout
package nnoc_pkg;

    localparam int USB_BYTE_W      = 8;
    localparam int NNOC_WORD_BYTES = 4;

    typedef struct packed {
        logic [$clog2(NNOC_WORD_BYTES+1)-1:0]    bytes;
        logic [USB_BYTE_W*NNOC_WORD_BYTES-1:0]   data;
    } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with registered full/empty/level
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flags come from registered state, so a same-cycle pop never frees room for a push.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
                full  <= (level == LVL_W'(DEPTH - 1));
                empty <= 1'b0;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
                empty <= (level == LVL_W'(1));
                full  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/usb_serial_word_bridge.sv
// rtl/usb_serial_word_bridge.sv - USB byte stream <-> nnoc word bridge; RX idle flush under USB_WORD_BRIDGE_RX_TIMEOUT_EN
module usb_serial_word_bridge
    import nnoc_pkg::*;
#(
    parameter int WORD_BYTES   = NNOC_WORD_BYTES,
    parameter int RX_DEPTH     = 16,
    parameter int TX_DEPTH     = 16,
    parameter int IDLE_TIMEOUT = 4800
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [USB_BYTE_W-1:0]                 usb_rx_data,
    input  logic                                  usb_rx_valid,
    output logic                                  usb_rx_ready,
    output logic [USB_BYTE_W-1:0]                 usb_tx_data,
    output logic                                  usb_tx_valid,
    input  logic                                  usb_tx_ready,
    output logic [USB_BYTE_W*WORD_BYTES-1:0]      rx_word_data,
    output logic [$clog2(WORD_BYTES+1)-1:0]       rx_word_bytes,
    output logic                                  rx_word_valid,
    input  logic                                  rx_word_ready,
    input  logic [USB_BYTE_W*WORD_BYTES-1:0]      tx_word_data,
    input  logic                                  tx_word_valid,
    output logic                                  tx_word_ready,
    output logic [$clog2(RX_DEPTH+1)-1:0]         rx_level,
    output logic [$clog2(TX_DEPTH+1)-1:0]         tx_level
);

    localparam int WORD_W = USB_BYTE_W * WORD_BYTES;
    localparam int CNT_W  = $clog2(WORD_BYTES + 1);
    localparam int IDX_W  = $clog2(WORD_BYTES);

    typedef struct packed {
        logic [CNT_W-1:0]  bytes;
        logic [WORD_W-1:0] data;
    } rx_word_t;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    logic [CNT_W-1:0]            byte_cnt;
    logic [WORD_W-1:0]           pack_q;
    logic                        rx_last;
    logic                        rx_accept;
    logic                        rx_push;
    logic                        rx_pop;
    logic                        rx_full;
    logic                        rx_empty;
    logic                        flush;
    logic [CNT_W-1:0]            rx_in_bytes;
    rx_word_t                    rx_in;
    rx_word_t                    rx_out;
    logic [$clog2(RX_DEPTH+1)-1:0] rx_lvl;

    assign rx_last      = (byte_cnt == CNT_W'(WORD_BYTES - 1));
    assign usb_rx_ready = !reset && !(rx_last && rx_full);
    assign rx_accept    = usb_rx_valid && usb_rx_ready;

`ifdef USB_WORD_BRIDGE_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              rx_idle;

    assign rx_idle     = (byte_cnt != '0) && !rx_accept;
    assign flush       = rx_idle && (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) && !rx_full;
    assign rx_in_bytes = flush ? byte_cnt : CNT_W'(WORD_BYTES);

    // Saturates at the threshold so a flush blocked by a full FIFO fires as soon as room appears.
    always_ff @(posedge clk) begin
        if (reset || !rx_idle || flush) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_W'(IDLE_TIMEOUT - 1)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    localparam int unused_idle_timeout = IDLE_TIMEOUT;

    assign flush       = 1'b0;
    assign rx_in_bytes = CNT_W'(WORD_BYTES);
`endif

    // The final lane bypasses the shift register so the word is pushed on the edge that accepts it.
    assign rx_push     = (rx_accept && rx_last) || flush;
    assign rx_in.bytes = rx_in_bytes;
    assign rx_in.data  = flush ? pack_q
                               : {usb_rx_data, pack_q[WORD_W-USB_BYTE_W-1:0]};
    assign rx_pop      = !reset && rx_word_ready && !rx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            pack_q   <= '0;
        end else if (rx_accept) begin
            if (rx_last) begin
                byte_cnt <= '0;
                pack_q   <= '0;
            end else begin
                pack_q[USB_BYTE_W*int'(byte_cnt) +: USB_BYTE_W] <= usb_rx_data;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end else if (flush) begin
            byte_cnt <= '0;
            pack_q   <= '0;
        end
    end

    sync_fifo #(.WIDTH($bits(rx_word_t)), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_in),
        .pop       (rx_pop),
        .pop_data  (rx_out),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_lvl)
    );

    assign rx_word_valid = !reset && !rx_empty;
    assign rx_word_data  = reset ? '0 : rx_out.data;
    assign rx_word_bytes = reset ? '0 : rx_out.bytes;
    assign rx_level      = reset ? '0 : rx_lvl;

    tx_state_t                     tx_state;
    logic [WORD_W-1:0]             hold_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          tx_valid_q;
    logic                          tx_last;
    logic                          tx_push;
    logic                          tx_pop;
    logic                          tx_full;
    logic                          tx_empty;
    logic [WORD_W-1:0]             tx_fifo_data;
    logic [$clog2(TX_DEPTH+1)-1:0] tx_lvl;

    assign tx_last = (idx_q == IDX_W'(WORD_BYTES - 1));
    assign tx_push = !reset && tx_word_valid && !tx_full;
    assign tx_pop  = !reset && !tx_empty &&
                     ((tx_state == TX_IDLE) || (usb_tx_ready && tx_last));

    sync_fifo #(.WIDTH(WORD_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (tx_word_data),
        .pop       (tx_pop),
        .pop_data  (tx_fifo_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_lvl)
    );

    // hold_q shifts down one byte per transfer, so the current byte is always in the low lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            hold_q     <= '0;
            idx_q      <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        hold_q     <= tx_fifo_data;
                        idx_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_state   <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (usb_tx_ready) begin
                        if (!tx_last) begin
                            hold_q <= hold_q >> USB_BYTE_W;
                            idx_q  <= idx_q + 1'b1;
                        end else if (tx_pop) begin
                            hold_q <= tx_fifo_data;
                            idx_q  <= '0;
                        end else begin
                            tx_valid_q <= 1'b0;
                            tx_state   <= TX_IDLE;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign usb_tx_valid  = tx_valid_q && !reset;
    assign usb_tx_data   = reset ? '0 : hold_q[USB_BYTE_W-1:0];
    assign tx_word_ready = !reset && !tx_full;
    assign tx_level      = reset ? '0 : tx_lvl;

endmodule

// File: tb/tb_usb_serial_word_bridge.sv
// tb/tb_usb_serial_word_bridge.sv - randomized scoreboard bench for usb_serial_word_bridge (honours USB_WORD_BRIDGE_RX_TIMEOUT_EN)
module tb_usb_serial_word_bridge;

    localparam int WB  = 4;
    localparam int RXD = 16;
    localparam int TXD = 16;
    localparam int TO  = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  usb_rx_data;
    logic        usb_rx_valid;
    logic        usb_rx_ready;
    logic [7:0]  usb_tx_data;
    logic        usb_tx_valid;
    logic        usb_tx_ready;
    logic [31:0] rx_word_data;
    logic [2:0]  rx_word_bytes;
    logic        rx_word_valid;
    logic        rx_word_ready;
    logic [31:0] tx_word_data;
    logic        tx_word_valid;
    logic        tx_word_ready;
    logic [4:0]  rx_level;
    logic [4:0]  tx_level;

    always #5 clk = ~clk;

    usb_serial_word_bridge #(
        .WORD_BYTES(WB), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .usb_rx_data(usb_rx_data), .usb_rx_valid(usb_rx_valid), .usb_rx_ready(usb_rx_ready),
        .usb_tx_data(usb_tx_data), .usb_tx_valid(usb_tx_valid), .usb_tx_ready(usb_tx_ready),
        .rx_word_data(rx_word_data), .rx_word_bytes(rx_word_bytes),
        .rx_word_valid(rx_word_valid), .rx_word_ready(rx_word_ready),
        .tx_word_data(tx_word_data), .tx_word_valid(tx_word_valid), .tx_word_ready(tx_word_ready),
        .rx_level(rx_level), .tx_level(tx_level)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: host bytes grouped in fours (little-endian), TX words split into bytes.
    logic [7:0]  rx_part[$];
    logic [31:0] rx_exp_data[$];
    int          rx_exp_bytes[$];
    logic [7:0]  tx_exp[$];
    int          rx_seen = 0;
    int          tx_seen = 0;
    bit          tx_hold_prev = 0;
    logic [7:0]  tx_prev_data;

    always @(negedge clk) begin
        logic [31:0] w;
        if (!reset) begin
            if (usb_rx_valid && usb_rx_ready) begin
                rx_part.push_back(usb_rx_data);
                if (rx_part.size() == WB) begin
                    w = 0;
                    for (int i = 0; i < WB; i++) w = w | (32'(rx_part[i]) << (8 * i));
                    rx_exp_data.push_back(w);
                    rx_exp_bytes.push_back(WB);
                    rx_part.delete();
                end
            end
            if (tx_word_valid && tx_word_ready)
                for (int i = 0; i < WB; i++) tx_exp.push_back(tx_word_data[8*i +: 8]);
            if (rx_word_valid && rx_word_ready) begin
                rx_seen++;
                check("rx_word_expected", 64'(rx_exp_data.size() > 0), 64'(1));
                if (rx_exp_data.size() > 0) begin
                    check("rx_word_data", 64'(rx_word_data), 64'(rx_exp_data.pop_front()));
                    check("rx_word_bytes", 64'(rx_word_bytes), 64'(rx_exp_bytes.pop_front()));
                end
            end
            if (tx_hold_prev) begin
                check("tx_valid_held", 64'(usb_tx_valid), 64'(1));
                check("tx_data_held", 64'(usb_tx_data), 64'(tx_prev_data));
            end
            if (usb_tx_valid && usb_tx_ready) begin
                tx_seen++;
                check("tx_byte_expected", 64'(tx_exp.size() > 0), 64'(1));
                if (tx_exp.size() > 0)
                    check("tx_byte_order", 64'(usb_tx_data), 64'(tx_exp.pop_front()));
            end
            tx_hold_prev = usb_tx_valid && !usb_tx_ready;
            tx_prev_data = usb_tx_data;
        end else begin
            tx_hold_prev = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rx_byte(input logic [7:0] b);
        int n = 0;
        usb_rx_data  = b;
        usb_rx_valid = 1'b1;
        @(negedge clk);
        while (!usb_rx_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("rx_byte_accept_wait", 64'(n < 300), 64'(1));
        @(posedge clk);
        #1 usb_rx_valid = 1'b0;
    endtask

    task automatic send_tx_word(input logic [31:0] w);
        int n = 0;
        tx_word_data  = w;
        tx_word_valid = 1'b1;
        @(negedge clk);
        while (!tx_word_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("tx_word_accept_wait", 64'(n < 300), 64'(1));
        @(posedge clk);
        #1 tx_word_valid = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        rx_word_ready = 1'b1;
        usb_tx_ready  = 1'b1;
        while ((rx_exp_data.size() > 0 || tx_exp.size() > 0) && n < 500) begin
            n++;
            tick(1);
        end
        tick(2);
        check("drain_rx_empty", 64'(rx_exp_data.size()), 64'(0));
        check("drain_tx_empty", 64'(tx_exp.size()), 64'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [7:0] t2_bytes [8];
    bit         rx_done;
    bit         tx_done;

    initial begin
        reset = 1'b1;
        usb_rx_data = 0; usb_rx_valid = 0; usb_tx_ready = 0;
        rx_word_ready = 0; tx_word_data = 0; tx_word_valid = 0;
        t2_bytes = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04, 8'h03, 8'h02, 8'h01};

        // Reset state
        @(negedge clk);
        check("rst_usb_rx_ready", 64'(usb_rx_ready), 64'(0));
        check("rst_tx_word_ready", 64'(tx_word_ready), 64'(0));
        check("rst_rx_word_valid", 64'(rx_word_valid), 64'(0));
        check("rst_usb_tx_valid", 64'(usb_tx_valid), 64'(0));
        tick(2);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_usb_rx_ready", 64'(usb_rx_ready), 64'(1));
        check("post_rst_tx_word_ready", 64'(tx_word_ready), 64'(1));
        check("post_rst_levels", 64'({rx_level, tx_level}), 64'(0));
        tick(1);

        // 1: four host bytes make one word, visible right after the last byte
        send_rx_byte(8'h11); send_rx_byte(8'h22); send_rx_byte(8'h33);
        @(negedge clk);
        check("t1_not_yet_valid", 64'(rx_word_valid), 64'(0));
        tick(1);
        send_rx_byte(8'h44);
        @(negedge clk);
        check("t1_valid", 64'(rx_word_valid), 64'(1));
        check("t1_data", 64'(rx_word_data), 64'h44332211);
        check("t1_bytes", 64'(rx_word_bytes), 64'(4));
        check("t1_level", 64'(rx_level), 64'(1));
        tick(1);
        rx_word_ready = 1'b1;
        tick(1);
        rx_word_ready = 1'b0;
        @(negedge clk);
        check("t1_level_after_pop", 64'(rx_level), 64'(0));
        tick(1);

        // 2: two TX words stream out back to back
        usb_tx_ready = 1'b1;
        tx_word_data = 32'hA1B2C3D4; tx_word_valid = 1'b1;
        @(negedge clk);
        check("t2_word0_ready", 64'(tx_word_ready), 64'(1));
        @(posedge clk); #1;
        tx_word_data = 32'h01020304;
        @(negedge clk);
        check("t2_latency_not_yet", 64'(usb_tx_valid), 64'(0));
        @(posedge clk); #1;
        tx_word_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_valid_no_bubble", 64'(usb_tx_valid), 64'(1));
            check("t2_byte", 64'(usb_tx_data), 64'(t2_bytes[i]));
        end
        @(negedge clk);
        check("t2_idle_after", 64'(usb_tx_valid), 64'(0));
        tick(1);

        // 3: RX FIFO full backpressure, then TX FIFO full
        rx_word_ready = 1'b0;
        for (int i = 0; i < RXD * WB + 3; i++) send_rx_byte(8'($urandom));
        usb_rx_data = 8'($urandom); usb_rx_valid = 1'b1;
        @(negedge clk);
        check("t3_level_full", 64'(rx_level), 64'(16));
        check("t3_rx_blocked", 64'(usb_rx_ready), 64'(0));
        tick(3);
        @(negedge clk);
        check("t3_rx_still_blocked", 64'(usb_rx_ready), 64'(0));
        @(posedge clk); #1;
        rx_word_ready = 1'b1;
        @(negedge clk);
        check("t3_pop_no_same_cycle_room", 64'(usb_rx_ready), 64'(0));
        @(posedge clk); #1;
        rx_word_ready = 1'b0;
        @(negedge clk);
        check("t3_room_after_pop", 64'(usb_rx_ready), 64'(1));
        check("t3_level_15", 64'(rx_level), 64'(15));
        @(posedge clk); #1;
        usb_rx_valid = 1'b0;
        @(negedge clk);
        check("t3_level_back_16", 64'(rx_level), 64'(16));
        tick(1);
        usb_tx_ready = 1'b0;
        for (int i = 0; i < TXD + 1; i++) send_tx_word($urandom);
        @(negedge clk);
        check("t3_tx_level_full", 64'(tx_level), 64'(16));
        check("t3_tx_word_ready_low", 64'(tx_word_ready), 64'(0));
        tick(1);
        drain_all();
        rx_word_ready = 1'b0;

        // 4: partial word handling
        send_rx_byte(8'hAA); send_rx_byte(8'hBB);
`ifdef USB_WORD_BRIDGE_RX_TIMEOUT_EN
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        check("t4_no_early_flush", 64'(rx_word_valid), 64'(0));
        @(negedge clk);
        check("t4_flush_valid", 64'(rx_word_valid), 64'(1));
        check("t4_flush_data", 64'(rx_word_data), 64'h0000BBAA);
        check("t4_flush_bytes", 64'(rx_word_bytes), 64'(2));
        rx_part.delete();
        rx_exp_data.push_back(32'h0000BBAA);
        rx_exp_bytes.push_back(2);
`else
        tick(TO + 10);
        @(negedge clk);
        check("t4_partial_held", 64'(rx_word_valid), 64'(0));
        tick(1);
        send_rx_byte(8'hCC); send_rx_byte(8'hDD);
        @(negedge clk);
        check("t4_word_valid", 64'(rx_word_valid), 64'(1));
        check("t4_word_data", 64'(rx_word_data), 64'hDDCCBBAA);
        check("t4_word_bytes", 64'(rx_word_bytes), 64'(4));
`endif
        tick(1);
        drain_all();

        // 5: randomized traffic with random backpressure on both sides
        rx_done = 0; tx_done = 0;
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    tick($urandom_range(0, 3));
                    send_rx_byte(8'($urandom));
                end
                rx_done = 1;
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    tick($urandom_range(0, 5));
                    send_tx_word($urandom);
                end
                tx_done = 1;
            end
            begin
                int c = 0;
                while (!(rx_done && tx_done) && c < 5000) begin
                    c++;
                    @(posedge clk); #1;
                    rx_word_ready = 1'($urandom_range(0, 1));
                    usb_tx_ready  = 1'($urandom_range(0, 1));
                end
                check("t5_producers_done", 64'(rx_done && tx_done), 64'(1));
            end
        join
        drain_all();
        check("t5_no_partial", 64'(rx_part.size()), 64'(0));

        // 6: reset mid-transfer discards everything
        rx_word_ready = 1'b0; usb_tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_rx_byte(8'($urandom));
        send_tx_word(32'hDEADBEEF);
        send_tx_word(32'hCAFEF00D);
        tick(2);
        @(negedge clk);
        check("t6_in_send", 64'(usb_tx_valid), 64'(1));
        check("t6_levels_before", 64'({rx_level, tx_level}), 64'({5'd1, 5'd1}));
        @(posedge clk); #1;
        reset = 1'b1;
        rx_part.delete(); rx_exp_data.delete(); rx_exp_bytes.delete(); tx_exp.delete();
        @(negedge clk);
        check("t6_valids_in_reset", 64'({usb_tx_valid, rx_word_valid}), 64'(0));
        @(negedge clk);
        check("t6_levels_in_reset", 64'({rx_level, tx_level}), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        usb_tx_ready = 1'b1; rx_word_ready = 1'b1;
        rx_seen = 0; tx_seen = 0;
        @(negedge clk);
        check("t6_valids_after", 64'({usb_tx_valid, rx_word_valid}), 64'(0));
        check("t6_levels_after", 64'({rx_level, tx_level}), 64'(0));
        tick(20);
        check("t6_no_stale_rx", 64'(rx_seen), 64'(0));
        check("t6_no_stale_tx", 64'(tx_seen), 64'(0));
        send_rx_byte(8'h01); send_rx_byte(8'h02); send_rx_byte(8'h03); send_rx_byte(8'h04);
        tick(5);
        check("t6_fresh_word_seen", 64'(rx_seen), 64'(1));
        check("t6_model_drained", 64'(rx_exp_data.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
